chunk_serial_adder: RTL and testbench
=====================================

# chunk_serial_adder

Parametrised multi-cycle adder that sums two WIDTH-bit operands CHUNK bits per clock, LSB chunk first, holding the inter-chunk carry in a register. It is the sequential successor to the 4-bit ripple-carry adder. It trades latency for a short carry chain and sits behind valid/ready handshakes on both sides, so it drops directly into streaming datapaths.

## Interface

Parameters:
- WIDTH, 16, operand and sum width in bits.
- CHUNK, 4, bits processed per cycle. WIDTH % CHUNK must be 0, otherwise elaboration fails. NCHUNK = WIDTH/CHUNK.

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  asynchronous reset, active low.
- in_valid  input  1  operands and c_in are valid.
- in_ready  output  1  block can accept operands.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- c_in  input  1  carry in (borrow in when sub=1).
- sub  input  1  subtract mode. Present only with SUB_EN.
- out_valid  output  1  result valid.
- out_ready  input  1  downstream accepts the result.
- s  output  WIDTH  sum/difference, registered.
- c_out  output  1  carry out of the MSB, registered.
- ovf  output  1  two's-complement overflow, registered.

## Operation

- FSM states: IDLE, CALC, DONE.
- in_ready = (state == IDLE), driven combinationally from the state register.
- IDLE:
  - Accept when in_valid && in_ready.
  - Latch a, b, c_in (and sub). Clear the chunk counter cnt to 0. Go to CALC.
  - in_valid is ignored in every other state.
- CALC, once per cycle:
  - Compute {carry, s[cnt*CHUNK +: CHUNK]} = a_chunk + b_chunk + carry.
  - The carry register starts at c_in.
  - Increment cnt.
  - On the chunk where cnt == NCHUNK-1: set c_out = final carry, ovf = carry into MSB XOR carry out of MSB, then go to DONE.
- DONE:
  - out_valid = 1. s, c_out and ovf are held stable.
  - On out_valid && out_ready, go to IDLE.
  - No new operand is accepted in the same cycle as the result handshake.
- s updates chunk by chunk during CALC. Its value is meaningful only while out_valid = 1.
- Arithmetic is modulo 2^WIDTH. c_out carries the bit lost to the modulo.
- CHUNK == WIDTH is legal: CALC lasts exactly one cycle.

## Timing

- Reset (rst_n low, asynchronous):
  - state = IDLE, cnt = 0, carry = 0.
  - s = 0, c_out = 0, ovf = 0, out_valid = 0.
  - in_ready = 1.
- Latency:
  - Operands are accepted at edge E0.
  - Chunk k is registered at edge E(k+1).
  - out_valid rises after edge E(NCHUNK), i.e. NCHUNK cycles after acceptance.
- Throughput: one operation per NCHUNK+2 cycles when out_ready is held high. The extra cycles are DONE→IDLE and the IDLE accept cycle.
- Backpressure: DONE holds indefinitely while out_ready = 0, with outputs unchanged.
- out_ready while not in DONE is ignored.
- Reset mid-CALC or mid-DONE: the operation is aborted immediately, all outputs return to reset values, and no out_valid is produced for the aborted operation.

## Configuration

- SUB_EN defined:
  - The sub port exists and is latched with the operands.
  - sub=1 computes s = a − b − c_in, implemented as a + ~b + ~c_in.
  - In this mode c_out = 1 means no borrow. ovf is signed overflow of the subtraction.
- SUB_EN undefined:
  - The sub port is absent and the block only adds.
  - No inversion logic is generated.

## Test plan

- Reset check: drive rst_n=0 mid-sequence → s=0, c_out=0, ovf=0, out_valid=0, in_ready=1 asynchronously.
- Basic add (WIDTH=16, CHUNK=4): a=0x0003, b=0x0005, c_in=0 → s=0x0008, c_out=0, ovf=0. out_valid rises exactly 4 cycles after accept.
- Full carry propagation: 0xFFFF + 0x0001, c_in=0 → s=0x0000, c_out=1, ovf=0. Then 0x7FFF + 0x0001 → s=0x8000, c_out=0, ovf=1.
- Backpressure and abort:
  - Hold out_ready=0 for 5 cycles in DONE → s/c_out/ovf stable, in_ready=0, and a concurrent in_valid is not accepted.
  - Separately, assert rst_n=0 in the 2nd CALC cycle → out_valid never rises for that operation.
- Single-chunk config (WIDTH=CHUNK=4): 0xF + 0xF, c_in=1 → s=0xF, c_out=1, out_valid 1 cycle after accept.
- SUB_EN: 0x0005 − 0x0003, c_in=0 → s=0x0002, c_out=1. Then 0x0003 − 0x0005 → s=0xFFFE, c_out=0, ovf=0.

Source files
------------

// File: rtl/chunk_serial_adder.sv
// Multi-cycle adder: sums two WIDTH-bit operands CHUNK bits per clock, LSB chunk first,
// behind valid/ready handshakes. Define SUB_EN to add the sub port (a - b - c_in mode).
module chunk_serial_adder #(
   parameter int WIDTH = 16,
   parameter int CHUNK = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             c_in,
`ifdef SUB_EN
   input  logic             sub,
`endif
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] s,
   output logic             c_out,
   output logic             ovf
);

   localparam int NCHUNK = WIDTH / CHUNK;
   localparam int CNT_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NCHUNK - 1);

   if (CHUNK < 1 || (WIDTH % CHUNK) != 0) begin : g_bad_chunk
      $error("chunk_serial_adder: WIDTH must be a non-zero multiple of CHUNK");
   end

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t           r_state;
   logic [WIDTH-1:0] r_a;
   logic [WIDTH-1:0] r_b;
   logic [WIDTH-1:0] r_s;
   logic [CNT_W-1:0] r_cnt;
   logic             r_carry;
   logic             r_c_out;
   logic             r_ovf;
   logic             r_out_valid;

   logic [WIDTH-1:0] w_b_in;
   logic             w_c_in;
   logic [CHUNK-1:0] w_sum;
   logic             w_cout;
   logic             w_ovf;

   // Subtraction is a + ~b + ~c_in; inverting before the operand register latches the mode.
`ifdef SUB_EN
   assign w_b_in = sub ? ~b : b;
   assign w_c_in = sub ? ~c_in : c_in;
`else
   assign w_b_in = b;
   assign w_c_in = c_in;
`endif

   // Operands shift right each CALC cycle, so the active chunk is always the low CHUNK bits.
   assign {w_cout, w_sum} = {1'b0, r_a[CHUNK-1:0]} + {1'b0, r_b[CHUNK-1:0]}
                          + {{CHUNK{1'b0}}, r_carry};

   // Carry into the MSB is a^b^sum at that bit; xor with carry out gives signed overflow.
   assign w_ovf = r_a[CHUNK-1] ^ r_b[CHUNK-1] ^ w_sum[CHUNK-1] ^ w_cout;

   assign in_ready  = (r_state == IDLE);
   assign out_valid = r_out_valid;
   assign s         = r_s;
   assign c_out     = r_c_out;
   assign ovf       = r_ovf;

   // NOTE: sequential state uses non-blocking assignments so every register samples
   // the pre-edge values of the others, independent of statement order.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= IDLE;
         r_a         <= '0;
         r_b         <= '0;
         r_s         <= '0;
         r_cnt       <= '0;
         r_carry     <= 1'b0;
         r_c_out     <= 1'b0;
         r_ovf       <= 1'b0;
         r_out_valid <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               if (in_valid) begin
                  r_a     <= a;
                  r_b     <= w_b_in;
                  r_carry <= w_c_in;
                  r_cnt   <= '0;
                  r_state <= CALC;
               end
            end
            CALC: begin
               // Result chunks enter at the top and slide down, landing LSB-first in place.
               r_s     <= (r_s >> CHUNK) | (WIDTH'(w_sum) << (WIDTH - CHUNK));
               r_a     <= r_a >> CHUNK;
               r_b     <= r_b >> CHUNK;
               r_carry <= w_cout;
               r_cnt   <= r_cnt + CNT_W'(1);
               if (r_cnt == LAST_CNT) begin
                  r_c_out     <= w_cout;
                  r_ovf       <= w_ovf;
                  r_out_valid <= 1'b1;
                  r_state     <= DONE;
               end
            end
            DONE: begin
               if (out_ready) begin
                  r_out_valid <= 1'b0;
                  r_state     <= IDLE;
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_chunk_serial_adder.sv
// Directed self-checking bench for chunk_serial_adder: a 16/4 instance and a 4/4 single-chunk
// instance. Subtract vectors run only when SUB_EN is defined.
module tb_chunk_serial_adder;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        sub;

   logic        in_valid, in_ready, out_valid, out_ready;
   logic [15:0] a, b, s;
   logic        c_in, c_out, ovf;

   logic        in_valid1, in_ready1, out_valid1, out_ready1;
   logic [3:0]  a1, b1, s1;
   logic        c_in1, c_out1, ovf1;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   chunk_serial_adder #(.WIDTH(16), .CHUNK(4)) u_dut16 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .a(a), .b(b), .c_in(c_in),
`ifdef SUB_EN
      .sub(sub),
`endif
      .out_valid(out_valid), .out_ready(out_ready), .s(s), .c_out(c_out), .ovf(ovf)
   );

   chunk_serial_adder #(.WIDTH(4), .CHUNK(4)) u_dut4 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid1), .in_ready(in_ready1),
      .a(a1), .b(b1), .c_in(c_in1),
`ifdef SUB_EN
      .sub(sub),
`endif
      .out_valid(out_valid1), .out_ready(out_ready1), .s(s1), .c_out(c_out1), .ovf(ovf1)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Present operands for one edge, then verify out_valid rises exactly 4 cycles after accept.
   task automatic start_op(input string tag, input logic [15:0] va, input logic [15:0] vb,
                           input logic vc);
      check({tag, "_in_ready_idle"}, in_ready, 1'b1);
      a = va; b = vb; c_in = vc; in_valid = 1'b1;
      step();
      in_valid = 1'b0;
      check({tag, "_in_ready_busy"}, in_ready, 1'b0);
      step(); step(); step();
      check({tag, "_valid_early"}, out_valid, 1'b0);
      step();
      check({tag, "_valid_lat4"}, out_valid, 1'b1);
   endtask

   task automatic expect_result(input string tag, input logic [15:0] es, input logic ec,
                                input logic eo);
      check({tag, "_s"}, s, es);
      check({tag, "_c_out"}, c_out, ec);
      check({tag, "_ovf"}, ovf, eo);
   endtask

   task automatic release_result(input string tag);
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      check({tag, "_valid_drop"}, out_valid, 1'b0);
      check({tag, "_in_ready_back"}, in_ready, 1'b1);
   endtask

   task automatic run_op(input string tag, input logic [15:0] va, input logic [15:0] vb,
                         input logic vc, input logic [15:0] es, input logic ec, input logic eo);
      start_op(tag, va, vb, vc);
      expect_result(tag, es, ec, eo);
      release_result(tag);
   endtask

   initial begin : stim
      int seen_valid;
      rst_n = 1'b0; sub = 1'b0;
      in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; c_in = 1'b0;
      in_valid1 = 1'b0; out_ready1 = 1'b0; a1 = '0; b1 = '0; c_in1 = 1'b0;

      // Reset state
      step(); step();
      check("rst_in_ready", in_ready, 1'b1);
      check("rst_out_valid", out_valid, 1'b0);
      check("rst_s", s, 16'h0000);
      check("rst_c_out", c_out, 1'b0);
      check("rst_ovf", ovf, 1'b0);
      check("rst_in_ready1", in_ready1, 1'b1);
      check("rst_out_valid1", out_valid1, 1'b0);
      rst_n = 1'b1;
      step();

      // Directed additions
      run_op("add_3_5",      16'h0003, 16'h0005, 1'b0, 16'h0008, 1'b0, 1'b0);
      run_op("add_ffff_1",   16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0);
      run_op("add_1234_cin", 16'h1234, 16'h4321, 1'b1, 16'h5556, 1'b0, 1'b0);
      run_op("add_8000_8000",16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1);
      run_op("add_abcd_cin", 16'hABCD, 16'h1234, 1'b1, 16'hBE02, 1'b0, 1'b0);

      // Backpressure: hold DONE 5 cycles with a competing in_valid present
      start_op("bp", 16'h00FF, 16'h0F01, 1'b0);
      a = 16'h1111; b = 16'h2222; in_valid = 1'b1;
      for (int i = 0; i < 5; i++) begin
         step();
         check("bp_hold_valid", out_valid, 1'b1);
         check("bp_hold_in_ready", in_ready, 1'b0);
         expect_result("bp_hold", 16'h1000, 1'b0, 1'b0);
      end
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      // Still IDLE here means the in_valid seen during the handshake edge was not taken.
      check("bp_no_accept_in_ready", in_ready, 1'b1);
      check("bp_no_accept_valid", out_valid, 1'b0);
      in_valid = 1'b0;
      step();

      // Overflow case, then asynchronous reset while parked in DONE
      start_op("add_7fff_1", 16'h7FFF, 16'h0001, 1'b0);
      expect_result("add_7fff_1", 16'h8000, 1'b0, 1'b1);
      #2 rst_n = 1'b0;
      #1;
      check("rst_done_s", s, 16'h0000);
      check("rst_done_ovf", ovf, 1'b0);
      check("rst_done_valid", out_valid, 1'b0);
      check("rst_done_in_ready", in_ready, 1'b1);
      step();
      rst_n = 1'b1;
      step();

      // Abort in the 2nd CALC cycle: no out_valid for that operation
      check("abort_in_ready_idle", in_ready, 1'b1);
      a = 16'h0003; b = 16'h0005; c_in = 1'b0; in_valid = 1'b1;
      step();
      in_valid = 1'b0;
      step();
      rst_n = 1'b0;
      #1;
      check("abort_c_out", c_out, 1'b0);
      check("abort_in_ready", in_ready, 1'b1);
      step();
      rst_n = 1'b1;
      seen_valid = 0;
      for (int i = 0; i < 8; i++) begin
         step();
         if (out_valid) seen_valid++;
      end
      check("abort_no_valid", seen_valid, 0);
      check("abort_idle", in_ready, 1'b1);

      // Operation after abort still works
      run_op("post_abort", 16'h0F0F, 16'h00F1, 1'b0, 16'h1000, 1'b0, 1'b0);

`ifdef SUB_EN
      sub = 1'b1;
      run_op("sub_5_3",    16'h0005, 16'h0003, 1'b0, 16'h0002, 1'b1, 1'b0);
      run_op("sub_3_5",    16'h0003, 16'h0005, 1'b0, 16'hFFFE, 1'b0, 1'b0);
      run_op("sub_8000_1", 16'h8000, 16'h0001, 1'b0, 16'h7FFF, 1'b1, 1'b1);
      sub = 1'b0;
`endif

      // Single-chunk instance: 0xF + 0xF + 1
      a1 = 4'hF; b1 = 4'hF; c_in1 = 1'b1; in_valid1 = 1'b1;
      step();
      in_valid1 = 1'b0;
      check("one_chunk_busy", in_ready1, 1'b0);
      check("one_chunk_valid_early", out_valid1, 1'b0);
      step();
      check("one_chunk_valid_lat1", out_valid1, 1'b1);
      check("one_chunk_s", s1, 4'hF);
      check("one_chunk_c_out", c_out1, 1'b1);
      check("one_chunk_ovf", ovf1, 1'b0);
      out_ready1 = 1'b1;
      step();
      out_ready1 = 1'b0;
      check("one_chunk_release", out_valid1, 1'b0);
      check("one_chunk_idle", in_ready1, 1'b1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
